// File: rtl/light_monitor.sv
// rtl/light_monitor.sv - passive safety/sequence/timing checker for a two-road traffic-light interface
//
// Ports:
//   clk           clock; every input is sampled on its rising edge
//   rst           asynchronous active-high reset
//   light_A       road A lamps, one-hot: 100 green, 010 yellow, 001 red
//   light_B       road B lamps, same encoding
//   clear         synchronous clear of the sticky err_* flags
//   err_conflict  sticky: both roads non-red in the same valid sample
//   err_encoding  sticky: a road presented a non-one-hot value
//   err_sequence  sticky: illegal colour transition or green alternation breach
//   err_timing    sticky: green, yellow or all-red dwell out of range
//   fault         registered OR of the four err_* flags (one clock behind them)
//   cycle_count   red->green entries of road A, wrapping at 16 bits
module light_monitor #(
    parameter int GREEN_MIN  = 6,
    parameter int GREEN_MAX  = 7,
    parameter int YELLOW_LEN = 1,
    parameter int ALLRED_MIN = 1,
    parameter int DW         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  light_A,
    input  logic [2:0]  light_B,
    input  logic        clear,
    output logic        err_conflict,
    output logic        err_encoding,
    output logic        err_sequence,
    output logic        err_timing,
    output logic        fault,
    output logic [15:0] cycle_count
);

    localparam logic [2:0] C_G = 3'b100;
    localparam logic [2:0] C_Y = 3'b010;
    localparam logic [2:0] C_R = 3'b001;

    localparam logic [DW-1:0] D_MAX  = '1;
    localparam logic [DW-1:0] D_ONE  = DW'(1);
    localparam logic [DW-1:0] G_MIN  = DW'(GREEN_MIN);
    localparam logic [DW-1:0] G_MAX  = DW'(GREEN_MAX);
    localparam logic [DW-1:0] Y_LEN  = DW'(YELLOW_LEN);
    localparam logic [DW-1:0] AR_MIN = DW'(ALLRED_MIN);

    typedef enum logic [1:0] {
        LG_NONE = 2'd0,
        LG_A    = 2'd1,
        LG_B    = 2'd2
    } last_green_t;

    typedef struct packed {
        logic          seq;
        logic          tim;
        logic          enter_g;
        logic          r2g;
        logic [DW-1:0] dwell;
    } road_res_t;

    logic [2:0]    prev_a, prev_b, prev_a_n, prev_b_n;
    logic [DW-1:0] dwell_a, dwell_b, dwell_a_n, dwell_b_n;
    logic [DW-1:0] allred_cnt, allred_cnt_n;
    logic          primed, primed_n;
    last_green_t   last_green, last_green_n;
    logic [15:0]   cycle_count_n;

    logic          valid_a, valid_b;
    logic          new_conflict, new_encoding, new_sequence, new_timing;
    road_res_t     res_a, res_b;

    // Per-road dwell update and transition checks for one primed, valid sample.
    function automatic road_res_t road_step(input logic [2:0] p, input logic [DW-1:0] d,
                                            input logic [2:0] c);
        road_res_t r;
        r = '0;
        if (c == p) begin
            r.dwell = (d == D_MAX) ? d : d + 1'b1;
            // Flag on the sample that pushes the dwell one past its limit, not at exit.
            if (c == C_G && d == G_MAX) r.tim = 1'b1;
            if (c == C_Y && d == Y_LEN) r.tim = 1'b1;
        end else begin
            r.dwell   = D_ONE;
            r.seq     = !((p == C_R && c == C_G) || (p == C_G && c == C_Y) ||
                          (p == C_Y && c == C_R));
            if (p == C_G && d < G_MIN)  r.tim = 1'b1;
            if (p == C_Y && d != Y_LEN) r.tim = 1'b1;
            r.enter_g = (c == C_G);
            r.r2g     = (p == C_R) && (c == C_G);
        end
        return r;
    endfunction

    assign valid_a = (light_A == C_G) || (light_A == C_Y) || (light_A == C_R);
    assign valid_b = (light_B == C_G) || (light_B == C_Y) || (light_B == C_R);

    always_comb begin
        prev_a_n      = prev_a;
        prev_b_n      = prev_b;
        dwell_a_n     = dwell_a;
        dwell_b_n     = dwell_b;
        allred_cnt_n  = allred_cnt;
        primed_n      = primed;
        last_green_n  = last_green;
        cycle_count_n = cycle_count;
        new_sequence  = 1'b0;
        new_timing    = 1'b0;
        res_a         = road_step(prev_a, dwell_a, light_A);
        res_b         = road_step(prev_b, dwell_b, light_B);

        new_encoding  = !valid_a || !valid_b;
        new_conflict  = valid_a && valid_b && (light_A != C_R) && (light_B != C_R);

        // A sample with any badly encoded road is ignored by the sequence and timing
        // checkers and leaves all tracking state (both roads, all-red run) untouched.
        if (valid_a && valid_b) begin
            if (!primed) begin
                prev_a_n     = light_A;
                prev_b_n     = light_B;
                dwell_a_n    = D_ONE;
                dwell_b_n    = D_ONE;
                allred_cnt_n = (light_A == C_R && light_B == C_R) ? D_ONE : '0;
                primed_n     = 1'b1;
            end else begin
                prev_a_n     = light_A;
                prev_b_n     = light_B;
                dwell_a_n    = res_a.dwell;
                dwell_b_n    = res_b.dwell;
                new_sequence = res_a.seq | res_b.seq;
                new_timing   = res_a.tim | res_b.tim;
                // Both alternation checks compare against the pre-sample last_green.
                if (res_a.enter_g) begin
                    if (last_green == LG_A) new_sequence = 1'b1;
                    last_green_n = LG_A;
                end
                if (res_b.enter_g) begin
                    if (last_green == LG_B) new_sequence = 1'b1;
                    last_green_n = LG_B;
                end
                // allred_cnt holds the both-red run that ended just before this sample.
                if ((res_a.r2g || res_b.r2g) && allred_cnt < AR_MIN) new_timing = 1'b1;
                if (res_a.r2g) cycle_count_n = cycle_count + 16'd1;
                if (light_A == C_R && light_B == C_R)
                    allred_cnt_n = (allred_cnt == D_MAX) ? allred_cnt : allred_cnt + 1'b1;
                else
                    allred_cnt_n = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_a       <= C_R;
            prev_b       <= C_R;
            dwell_a      <= '0;
            dwell_b      <= '0;
            allred_cnt   <= '0;
            primed       <= 1'b0;
            last_green   <= LG_NONE;
            cycle_count  <= '0;
            err_conflict <= 1'b0;
            err_encoding <= 1'b0;
            err_sequence <= 1'b0;
            err_timing   <= 1'b0;
            fault        <= 1'b0;
        end else begin
            prev_a       <= prev_a_n;
            prev_b       <= prev_b_n;
            dwell_a      <= dwell_a_n;
            dwell_b      <= dwell_b_n;
            allred_cnt   <= allred_cnt_n;
            primed       <= primed_n;
            last_green   <= last_green_n;
            cycle_count  <= cycle_count_n;
            // A new error in the same cycle as clear keeps its flag set.
            err_conflict <= (err_conflict & ~clear) | new_conflict;
            err_encoding <= (err_encoding & ~clear) | new_encoding;
            err_sequence <= (err_sequence & ~clear) | new_sequence;
            err_timing   <= (err_timing   & ~clear) | new_timing;
            fault        <= err_conflict | err_encoding | err_sequence | err_timing;
        end
    end

endmodule
